// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single 64-bit memory port between the instruction fetch unit
// (IFU) and the load/store unit (LSU). Exactly one transaction is in flight
// at a time: a requester is granted in IDLE, the request is presented on the
// memory port until accepted, the response (or a timeout) is captured, and a
// one-cycle response pulse is returned to the requester that owns it.
//
// Parameters
//   RR          : 1 = round-robin between IFU and LSU, 0 = LSU always wins ties
//   MEM_LAT_MAX : WAIT-state cycle limit before a timeout response (1..256)
//
// Ports
//   clock, reset             : system clock, synchronous active-high reset
//   ifu_req_* / ifu_resp_*   : fetch request (PC) and selected 32-bit instruction
//   lsu_req_* / lsu_resp_*   : load/store request and 64-bit read data
//   mem_req_* / mem_resp_*   : shared physical memory port (8-byte aligned)
//   busy                     : high whenever the arbiter is not in IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; grant at most one requester this cycle
// ISSUE | mem_req_valid high with latched fields, waiting for mem_req_ready
// WAIT  | request accepted, counting cycles until response or timeout
// RESP  | one-cycle response pulse to the owner, then back to IDLE

module mem_port_arbiter #(
    parameter int RR          = 1,
    parameter int MEM_LAT_MAX = 255
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_resp_inst,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // WAIT counter starts at 0 in the first WAIT cycle, so the timeout fires
    // in the MEM_LAT_MAX-th WAIT cycle.
    localparam logic [7:0] LAT_TC = 8'(MEM_LAT_MAX - 1);

    state_t       state;
    state_t       state_nxt;
    logic         owner;
    logic         last_grant;
    logic [63:2]  lat_addr;
    logic         lat_wen;
    logic [63:0]  lat_wdata;
    logic [7:0]   lat_wmask;
    logic [63:0]  rdata;
    logic         err;
    logic [7:0]   wait_cnt;

    logic         grant_ifu;
    logic         grant_lsu;
    logic         take_resp;
    logic         take_tmo;

    // Byte offset within a 32-bit word is irrelevant to an 8-byte port.
    logic         unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ifu_req_addr[1:0], lsu_req_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        take_resp = 1'b0;
        take_tmo  = 1'b0;
        case (state)
            IDLE: begin
                // No grant while reset is held: it would be discarded anyway.
                if (!reset) begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        if ((RR != 0) && (last_grant == OWN_LSU)) begin
                            grant_ifu = 1'b1;
                        end else begin
                            grant_lsu = 1'b1;
                        end
                    end else if (ifu_req_valid) begin
                        grant_ifu = 1'b1;
                    end else if (lsu_req_valid) begin
                        grant_lsu = 1'b1;
                    end
                end
                if (grant_ifu || grant_lsu) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response arriving in the timeout cycle still wins.
                if (mem_resp_valid) begin
                    take_resp = 1'b1;
                    state_nxt = RESP;
                end else if (wait_cnt == LAT_TC) begin
                    take_tmo  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_LSU;
            lat_addr   <= '0;
            lat_wen    <= 1'b0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (grant_ifu || grant_lsu) begin
                owner      <= grant_lsu;
                last_grant <= grant_lsu;
                lat_addr   <= grant_lsu ? lsu_req_addr[63:2] : ifu_req_addr[63:2];
                lat_wen    <= grant_lsu & lsu_req_wen;
                lat_wdata  <= grant_lsu ? lsu_req_wdata : '0;
                lat_wmask  <= grant_lsu ? lsu_req_wmask : '0;
                err        <= 1'b0;
            end

            if ((state == ISSUE) && mem_req_ready) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (take_resp) begin
                rdata <= mem_resp_rdata;
                err   <= 1'b0;
            end else if (take_tmo) begin
                rdata <= '0;
                err   <= 1'b1;
            end
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign busy           = (state != IDLE);

    assign mem_req_valid  = (state == ISSUE);
    assign mem_req_addr   = {lat_addr[63:3], 3'b000};
    assign mem_req_wen    = lat_wen;
    assign mem_req_wdata  = lat_wdata;
    assign mem_req_wmask  = lat_wmask;

    assign ifu_resp_valid = (state == RESP) && (owner == OWN_IFU) && !reset;
    assign ifu_resp_inst  = !ifu_resp_valid ? 32'd0 :
                            lat_addr[2]     ? rdata[63:32] : rdata[31:0];
    assign ifu_resp_err   = ifu_resp_valid & err;

    assign lsu_resp_valid = (state == RESP) && (owner == OWN_LSU) && !reset;
    assign lsu_resp_rdata = (lsu_resp_valid && !lat_wen) ? rdata : 64'd0;
    assign lsu_resp_err   = lsu_resp_valid & err;

endmodule
